switch_reader: RTL and testbench



---
 rtl/switch_reader_if.sv | 40 ++++
 rtl/switch_reader.sv | 140 ++++++++++++++
 tb/tb_switch_reader.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/switch_reader_if.sv
// ---------------------------------------------------------------------------
// switch_reader_if
// Peripheral read/write bus between the single-cycle core and the switch
// reader. The core drives the address, write strobe and write data. The
// peripheral returns combinational read data and a level interrupt.
//
// Signals:
//   iAddr  [1:0]  register word select (0 STATE, 1 EDGE, 2 MASK, 3 COUNT)
//   iWe           write strobe, sampled at the rising clock edge
//   iWData [31:0] write data
//   oRData [31:0] read data for iAddr, combinational
//   oIrq          interrupt request, active-high level
//
// Modports:
//   master  CPU side
//   slave   peripheral side
// ---------------------------------------------------------------------------
interface switch_reader_if;
    logic [1:0]  iAddr;
    logic        iWe;
    logic [31:0] iWData;
    logic [31:0] oRData;
    logic        oIrq;

    modport master (
        output iAddr,
        output iWe,
        output iWData,
        input  oRData,
        input  oIrq
    );

    modport slave (
        input  iAddr,
        input  iWe,
        input  iWData,
        output oRData,
        output oIrq
    );
endinterface

// File: rtl/switch_reader.sv
// ---------------------------------------------------------------------------
// switch_reader
// Memory-mapped input peripheral for the board switches. Each switch bit is
// synchronised and then debounced. Accepted changes set sticky EDGE flags and
// are counted in COUNT. A maskable level interrupt is raised from EDGE & MASK.
//
// Ports:
//   iClk            system clock, rising edge
//   iRst            synchronous active-high reset
//   iSwitch [WIDTH] raw asynchronous switch levels
//   bus             switch_reader_if.slave (iAddr, iWe, iWData, oRData, oIrq)
//
// Register map (word select):
//   0 STATE  debounced switch levels, read-only
//   1 EDGE   sticky change flags, write-1-to-clear
//   2 MASK   interrupt enable per bit, read/write
//   3 COUNT  16-bit count of accepted changes, read-only, wraps
// ---------------------------------------------------------------------------
module switch_reader #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 16
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [WIDTH-1:0] iSwitch,
    switch_reader_if.slave   bus
);

    // Counter value at which a held mismatch is accepted on the next edge.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] syncStage1;
    logic [WIDTH-1:0] syncStage2;
    logic [WIDTH-1:0] stateReg;
    logic [WIDTH-1:0] edgeReg;
    logic [WIDTH-1:0] maskReg;
    logic [15:0]      countReg;
    logic [CNT_W-1:0] debounceCnt [WIDTH];

    logic [WIDTH-1:0] changeEvt;
    logic [WIDTH-1:0] edgeClear;
    logic [15:0]      eventCount;
    logic [31:0]      rData;
    logic             unusedWData;

    // Only the low WIDTH bits of the write data reach any register. The
    // reduction keeps the rest of the bus visibly consumed.
    assign unusedWData = ^bus.iWData;

    // A bit produces a change event when its synchronised level has differed
    // from the accepted level for the full debounce window. The events are
    // also summed here, so simultaneous changes advance COUNT together.
    always_comb begin
        changeEvt  = '0;
        eventCount = '0;
        for (int i = 0; i < WIDTH; i++) begin
            changeEvt[i] = (syncStage2[i] != stateReg[i]) && (debounceCnt[i] == CNT_LAST);
            eventCount   = eventCount + 16'(changeEvt[i]);
        end
    end

    // Bits written as 1 to the EDGE word are cleared. Other addresses and
    // idle cycles clear nothing.
    always_comb begin
        edgeClear = '0;
        if (bus.iWe && (bus.iAddr == 2'd1)) begin
            edgeClear = bus.iWData[WIDTH-1:0];
        end
    end

    // Two-flop synchroniser in front of the debouncers. This is the only
    // place the raw switch pins are sampled.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            syncStage1 <= '0;
            syncStage2 <= '0;
        end else begin
            syncStage1 <= iSwitch;
            syncStage2 <= syncStage1;
        end
    end

    // Per-bit debounce counters. A counter runs only while the synchronised
    // level disagrees with STATE. It restarts from zero on any agreement,
    // which rejects short glitches, and also restarts once a change is
    // accepted.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int i = 0; i < WIDTH; i++) begin
                debounceCnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if ((syncStage2[i] == stateReg[i]) || (debounceCnt[i] == CNT_LAST)) begin
                    debounceCnt[i] <= '0;
                end else begin
                    debounceCnt[i] <= debounceCnt[i] + 1'b1;
                end
            end
        end
    end

    // Accepted levels, sticky flags, mask and change counter. An event only
    // fires on a mismatched bit, so XOR with the events loads the new level.
    // On EDGE the set term is ORed in after the clear, so a new event beats a
    // simultaneous write-1-to-clear of the same bit.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            stateReg <= '0;
            edgeReg  <= '0;
            maskReg  <= '0;
            countReg <= '0;
        end else begin
            stateReg <= stateReg ^ changeEvt;
            edgeReg  <= (edgeReg & ~edgeClear) | changeEvt;
            countReg <= countReg + eventCount;
            if (bus.iWe && (bus.iAddr == 2'd2)) begin
                maskReg <= bus.iWData[WIDTH-1:0];
            end
        end
    end

    // Combinational read mux. Each register is zero-extended to 32 bits, so
    // a load returns in the same CPU cycle and shows the pre-edge value
    // during a write.
    always_comb begin
        rData = '0;
        case (bus.iAddr)
            2'd0:    rData[WIDTH-1:0] = stateReg;
            2'd1:    rData[WIDTH-1:0] = edgeReg;
            2'd2:    rData[WIDTH-1:0] = maskReg;
            default: rData[15:0]      = countReg;
        endcase
    end

    assign bus.oRData = rData;
    assign bus.oIrq   = |(edgeReg & maskReg);

endmodule

// File: tb/tb_switch_reader.sv
// ---------------------------------------------------------------------------
// tb_switch_reader
// Directed bench for switch_reader with WIDTH=8 and DEBOUNCE_CYCLES=4.
// It covers reset and first acceptance latency, glitch rejection, ignored
// writes, write-1-to-clear, set-beats-clear, interrupt masking, COUNT
// wrap-around and reset in the middle of a debounce.
// ---------------------------------------------------------------------------
module tb_switch_reader;

    logic       iClk;
    logic       iRst;
    logic [7:0] iSwitch;
    logic [7:0] swVal;
    int         checks;
    int         failures;

    switch_reader_if bus ();

    switch_reader #(
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (16)
    ) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iSwitch (iSwitch),
        .bus     (bus)
    );

    // 10 ns clock
    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    // Watchdog so the run always ends even if the sequence stalls
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Count one comparison and report it if it does not match
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    // Single bus write: present for one edge, then release the strobe
    task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
        bus.iAddr  = addr;
        bus.iWData = data;
        bus.iWe    = 1'b1;
        tick();
        bus.iWe    = 1'b0;
        bus.iWData = '0;
    endtask

    // Combinational read of one register word and compare
    task automatic readCheck(input string tag, input logic [1:0] addr, input logic [31:0] expected);
        bus.iWe   = 1'b0;
        bus.iAddr = addr;
        #1;
        checkOutput(tag, bus.oRData, expected);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        iRst        = 1'b1;
        iSwitch     = 8'hA5;
        swVal       = 8'hA5;
        bus.iAddr   = 2'd0;
        bus.iWe     = 1'b0;
        bus.iWData  = '0;

        // Reset held for two edges with switches already high
        repeat (2) tick();
        iRst = 1'b0;
        readCheck("rst_state", 2'd0, 32'h0);
        readCheck("rst_edge",  2'd1, 32'h0);
        readCheck("rst_mask",  2'd2, 32'h0);
        readCheck("rst_count", 2'd3, 32'h0);
        checkOutput("rst_irq", {31'b0, bus.oIrq}, 32'h0);

        // STATE stays 0 through edge 5, accepts at edge 6
        for (int k = 1; k <= 5; k++) begin
            tick();
            readCheck($sformatf("lat_state_e%0d", k), 2'd0, 32'h0);
        end
        tick();
        readCheck("lat_state_e6", 2'd0, 32'h0000_00A5);
        readCheck("lat_edge",     2'd1, 32'h0000_00A5);
        readCheck("lat_count",    2'd3, 32'h0000_0004);

        // Three-cycle glitch on bit 0 is rejected
        iSwitch = 8'hA4;
        repeat (3) tick();
        iSwitch = 8'hA5;
        repeat (8) tick();
        readCheck("glitch_state", 2'd0, 32'h0000_00A5);
        readCheck("glitch_edge",  2'd1, 32'h0000_00A5);
        readCheck("glitch_count", 2'd3, 32'h0000_0004);

        // Writes to STATE and COUNT are ignored
        applyStimulus(2'd0, 32'hFFFF_FFFF);
        applyStimulus(2'd3, 32'hFFFF_FFFF);
        readCheck("ro_state", 2'd0, 32'h0000_00A5);
        readCheck("ro_count", 2'd3, 32'h0000_0004);

        // Write-1-to-clear, upper write bits ignored
        applyStimulus(2'd1, 32'hFFFF_FFA0);
        readCheck("w1c_a0", 2'd1, 32'h0000_0005);
        applyStimulus(2'd1, 32'h0000_0001);
        readCheck("w1c_01", 2'd1, 32'h0000_0004);
        applyStimulus(2'd1, 32'h0000_0000);
        readCheck("w1c_00", 2'd1, 32'h0000_0004);

        // Bit 2 falls and is accepted on the same edge that W1C clears bit 2
        iSwitch = 8'hA1;
        repeat (5) tick();
        readCheck("sbc_pre_state", 2'd0, 32'h0000_00A5);
        bus.iAddr  = 2'd1;
        bus.iWData = 32'h0000_0004;
        bus.iWe    = 1'b1;
        tick();
        bus.iWe    = 1'b0;
        readCheck("sbc_edge",  2'd1, 32'h0000_0004);
        readCheck("sbc_state", 2'd0, 32'h0000_00A1);
        readCheck("sbc_count", 2'd3, 32'h0000_0005);

        // Interrupt masking
        applyStimulus(2'd1, 32'h0000_0004);
        iSwitch = 8'hB1;
        repeat (6) tick();
        readCheck("irq_edge",  2'd1, 32'h0000_0010);
        readCheck("irq_count", 2'd3, 32'h0000_0006);
        checkOutput("irq_masked", {31'b0, bus.oIrq}, 32'h0);
        bus.iAddr  = 2'd2;
        bus.iWData = 32'h0000_0010;
        bus.iWe    = 1'b1;
        #1;
        checkOutput("mask_rdw",      bus.oRData, 32'h0);
        checkOutput("irq_pre_mask",  {31'b0, bus.oIrq}, 32'h0);
        tick();
        bus.iWe = 1'b0;
        checkOutput("irq_on", {31'b0, bus.oIrq}, 32'h1);
        readCheck("mask_val", 2'd2, 32'h0000_0010);
        bus.iAddr  = 2'd1;
        bus.iWData = 32'h0000_0010;
        bus.iWe    = 1'b1;
        #1;
        checkOutput("edge_rdw",     bus.oRData, 32'h0000_0010);
        checkOutput("irq_pre_w1c",  {31'b0, bus.oIrq}, 32'h1);
        tick();
        bus.iWe = 1'b0;
        checkOutput("irq_off", {31'b0, bus.oIrq}, 32'h0);
        readCheck("irq_edge_clr", 2'd1, 32'h0);

        // Drive COUNT from 6 to FFFF: 8191 full-byte toggles plus one bit
        swVal = 8'hB1;
        for (int t = 0; t < 8191; t++) begin
            swVal   = swVal ^ 8'hFF;
            iSwitch = swVal;
            repeat (5) tick();
        end
        swVal   = swVal ^ 8'h01;
        iSwitch = swVal;
        repeat (8) tick();
        readCheck("pre_wrap_count", 2'd3, 32'h0000_FFFF);
        readCheck("pre_wrap_state", 2'd0, 32'h0000_004F);

        // Two simultaneous changes wrap COUNT to 1
        iSwitch = 8'h49;
        repeat (5) tick();
        readCheck("wrap_e5_count", 2'd3, 32'h0000_FFFF);
        tick();
        readCheck("wrap_count", 2'd3, 32'h0000_0001);
        readCheck("wrap_state", 2'd0, 32'h0000_0049);

        // Reset in the middle of a bit-7 debounce
        iSwitch = 8'hC9;
        repeat (3) tick();
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        readCheck("mid_rst_state", 2'd0, 32'h0);
        readCheck("mid_rst_edge",  2'd1, 32'h0);
        readCheck("mid_rst_mask",  2'd2, 32'h0);
        readCheck("mid_rst_count", 2'd3, 32'h0);
        checkOutput("mid_rst_irq", {31'b0, bus.oIrq}, 32'h0);
        repeat (5) tick();
        readCheck("post_rst_e5_state", 2'd0, 32'h0);
        tick();
        readCheck("post_rst_e6_state", 2'd0, 32'h0000_00C9);
        readCheck("post_rst_count",    2'd3, 32'h0000_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
